// File: rtl/cphase_stream_issue.sv
// Controlled-phase gate over a streamed state vector: amplitudes with both control and
// target index bits set are rotated by the latched twiddle, all others pass through a matched delay.
module ccmult_pipelined #(
  parameter int TOTAL_WIDTH = 16,
  parameter int FRAC_WIDTH  = 8,
  parameter int LAT         = 6
) (
  input  logic                          clk,
  input  logic                          rst_s_n,
  input  logic signed [TOTAL_WIDTH-1:0] ar,
  input  logic signed [TOTAL_WIDTH-1:0] ai,
  input  logic signed [TOTAL_WIDTH-1:0] br,
  input  logic signed [TOTAL_WIDTH-1:0] bi,
  output logic signed [TOTAL_WIDTH-1:0] pr,
  output logic signed [TOTAL_WIDTH-1:0] pi
);
  localparam int PW = 2 * TOTAL_WIDTH + 1;

  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [PW-1:0] re_full, im_full, re_shift, im_shift;
  logic signed [TOTAL_WIDTH-1:0] re_reg [LAT];
  logic signed [TOTAL_WIDTH-1:0] im_reg [LAT];

  // Full-precision products, then floor shift and plain truncation (no rounding, no saturation)
  always_comb begin
    ar_x     = PW'(ar);
    ai_x     = PW'(ai);
    br_x     = PW'(br);
    bi_x     = PW'(bi);
    re_full  = ar_x * br_x - ai_x * bi_x;
    im_full  = ar_x * bi_x + ai_x * br_x;
    re_shift = re_full >>> FRAC_WIDTH;
    im_shift = im_full >>> FRAC_WIDTH;
  end

  always_ff @(posedge clk) begin
    if (!rst_s_n) begin
      for (int i = 0; i < LAT; i++) begin
        re_reg[i] <= '0;
        im_reg[i] <= '0;
      end
    end else begin
      re_reg[0] <= re_shift[TOTAL_WIDTH-1:0];
      im_reg[0] <= im_shift[TOTAL_WIDTH-1:0];
      for (int i = 1; i < LAT; i++) begin
        re_reg[i] <= re_reg[i-1];
        im_reg[i] <= im_reg[i-1];
      end
    end
  end

  assign pr = re_reg[LAT-1];
  assign pi = im_reg[LAT-1];
endmodule

module cphase_stream_issue #(
  parameter int NUM_QUBITS  = 3,
  parameter int CTRL_BIT    = 0,
  parameter int TGT_BIT     = 1,
  parameter int MULT_LAT    = 6,
  parameter int TOTAL_WIDTH = 16,
  parameter int FRAC_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_s_n,
  input  logic                          start,
  input  logic signed [TOTAL_WIDTH-1:0] tw_re,
  input  logic signed [TOTAL_WIDTH-1:0] tw_im,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [TOTAL_WIDTH-1:0] in_re,
  input  logic signed [TOTAL_WIDTH-1:0] in_im,
  output logic                          out_valid,
  output logic signed [TOTAL_WIDTH-1:0] out_re,
  output logic signed [TOTAL_WIDTH-1:0] out_im,
  output logic [NUM_QUBITS-1:0]         out_idx,
  output logic                          busy,
  output logic                          done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [NUM_QUBITS-1:0] IDX_LAST = '1;

  state_t                        state_reg;
  logic [NUM_QUBITS-1:0]         idx_reg;
  logic signed [TOTAL_WIDTH-1:0] tw_re_reg, tw_im_reg;
  logic                          in_ready_reg, busy_reg, done_reg;

  logic signed [TOTAL_WIDTH-1:0] iss_re_reg, iss_im_reg;
  logic [NUM_QUBITS-1:0]         iss_idx_reg;
  logic                          iss_sel_reg, iss_valid_reg;

  logic signed [TOTAL_WIDTH-1:0] byp_re_reg  [MULT_LAT];
  logic signed [TOTAL_WIDTH-1:0] byp_im_reg  [MULT_LAT];
  logic [NUM_QUBITS-1:0]         byp_idx_reg [MULT_LAT];
  logic [MULT_LAT-1:0]           byp_sel_reg, byp_valid_reg;

  logic signed [TOTAL_WIDTH-1:0] out_re_reg, out_im_reg;
  logic [NUM_QUBITS-1:0]         out_idx_reg;
  logic                          out_valid_reg;

  logic signed [TOTAL_WIDTH-1:0] mult_re, mult_im;
  logic                          accept, pipe_busy;

  assign accept    = in_valid & in_ready_reg;
  assign pipe_busy = iss_valid_reg | (|byp_valid_reg);

  always_ff @(posedge clk) begin
    if (!rst_s_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      tw_re_reg    <= '0;
      tw_im_reg    <= '0;
      in_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (start) begin
          state_reg    <= RUN;
          tw_re_reg    <= tw_re;
          tw_im_reg    <= tw_im;
          idx_reg      <= '0;
          in_ready_reg <= 1'b1;
          busy_reg     <= 1'b1;
        end
        RUN: if (accept) begin
          idx_reg <= idx_reg + NUM_QUBITS'(1);
          if (idx_reg == IDX_LAST) begin
            state_reg    <= DRAIN;
            in_ready_reg <= 1'b0;
          end
        end
        // Pipeline empty while the output register holds a sample: that sample is the last one
        DRAIN: if (!pipe_busy && out_valid_reg) begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_s_n) begin
      iss_re_reg    <= '0;
      iss_im_reg    <= '0;
      iss_idx_reg   <= '0;
      iss_sel_reg   <= 1'b0;
      iss_valid_reg <= 1'b0;
    end else begin
      iss_valid_reg <= accept;
      if (accept) begin
        iss_re_reg  <= in_re;
        iss_im_reg  <= in_im;
        iss_idx_reg <= idx_reg;
        iss_sel_reg <= idx_reg[CTRL_BIT] & idx_reg[TGT_BIT];
      end
    end
  end

  ccmult_pipelined #(
    .TOTAL_WIDTH(TOTAL_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH),
    .LAT        (MULT_LAT)
  ) u_mult (
    .clk    (clk),
    .rst_s_n(rst_s_n),
    .ar     (iss_re_reg),
    .ai     (iss_im_reg),
    .br     (tw_re_reg),
    .bi     (tw_im_reg),
    .pr     (mult_re),
    .pi     (mult_im)
  );

  // Bypass line is exactly as deep as the multiplier so both paths land on the same edge
  always_ff @(posedge clk) begin
    if (!rst_s_n) begin
      for (int i = 0; i < MULT_LAT; i++) begin
        byp_re_reg[i]  <= '0;
        byp_im_reg[i]  <= '0;
        byp_idx_reg[i] <= '0;
      end
      byp_sel_reg   <= '0;
      byp_valid_reg <= '0;
    end else begin
      byp_re_reg[0]    <= iss_re_reg;
      byp_im_reg[0]    <= iss_im_reg;
      byp_idx_reg[0]   <= iss_idx_reg;
      byp_sel_reg[0]   <= iss_sel_reg;
      byp_valid_reg[0] <= iss_valid_reg;
      for (int i = 1; i < MULT_LAT; i++) begin
        byp_re_reg[i]    <= byp_re_reg[i-1];
        byp_im_reg[i]    <= byp_im_reg[i-1];
        byp_idx_reg[i]   <= byp_idx_reg[i-1];
        byp_sel_reg[i]   <= byp_sel_reg[i-1];
        byp_valid_reg[i] <= byp_valid_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_s_n) begin
      out_re_reg    <= '0;
      out_im_reg    <= '0;
      out_idx_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= byp_valid_reg[MULT_LAT-1];
      if (byp_valid_reg[MULT_LAT-1]) begin
        out_re_reg  <= byp_sel_reg[MULT_LAT-1] ? mult_re : byp_re_reg[MULT_LAT-1];
        out_im_reg  <= byp_sel_reg[MULT_LAT-1] ? mult_im : byp_im_reg[MULT_LAT-1];
        out_idx_reg <= byp_idx_reg[MULT_LAT-1];
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign out_valid = out_valid_reg;
  assign out_re    = out_re_reg;
  assign out_im    = out_im_reg;
  assign out_idx   = out_idx_reg;
endmodule

// File: tb/tb_cphase_stream_issue.sv
// Directed bench for cphase_stream_issue at NUM_QUBITS=2, CTRL=0, TGT=1, Q8.8 samples.
module tb_cphase_stream_issue;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_s_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic signed [W-1:0] tw_re = '0, tw_im = '0, in_re = '0, in_im = '0;
  logic in_ready, out_valid, busy, done;
  logic signed [W-1:0] out_re, out_im;
  logic [1:0] out_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         oq_cyc[$];
  logic [W-1:0] oq_re[$];
  logic [W-1:0] oq_im[$];
  logic [1:0] oq_idx[$];
  int         dq[$];

  logic [W-1:0] stim_re[4], stim_im[4], exp_re[4], exp_im[4];
  int acc_edge[4];
  int n_acc;

  cphase_stream_issue #(
    .NUM_QUBITS(2), .CTRL_BIT(0), .TGT_BIT(1), .MULT_LAT(6),
    .TOTAL_WIDTH(16), .FRAC_WIDTH(8)
  ) dut (
    .clk(clk), .rst_s_n(rst_s_n), .start(start), .tw_re(tw_re), .tw_im(tw_im),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output sample and done pulse with the edge number that produced it
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      oq_cyc.push_back(cyc);
      oq_re.push_back(out_re);
      oq_im.push_back(out_im);
      oq_idx.push_back(out_idx);
    end
    if (done === 1'b1) dq.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    oq_cyc.delete(); oq_re.delete(); oq_im.delete(); oq_idx.delete(); dq.delete();
  endtask

  task automatic set_vec(input int i, input int sr, input int si, input int er, input int ei);
    stim_re[i] = W'(sr); stim_im[i] = W'(si);
    exp_re[i]  = W'(er); exp_im[i]  = W'(ei);
  endtask

  task automatic do_start(input int twr, input int twi);
    clear_logs();
    start = 1'b1; tw_re = W'(twr); tw_im = W'(twi);
    @(posedge clk); #1;
    start = 1'b0; tw_re = '0; tw_im = '0;
  endtask

  // Streams stim[0..3]; pat gives in_valid for the first npat cycles, 1 afterwards
  task automatic do_stream(input int npat, input logic [15:0] pat, input int start_at);
    n_acc = 0;
    for (int i = 0; i < 4; i++) acc_edge[i] = -100;
    for (int c = 0; c < 40 && n_acc < 4; c++) begin
      logic v;
      v = (c < npat) ? pat[c] : 1'b1;
      start = (c == start_at);
      tw_re = (c == start_at) ? W'(0) : W'(0);
      tw_im = (c == start_at) ? W'(256) : W'(0);
      in_valid = v;
      in_re = stim_re[n_acc];
      in_im = stim_im[n_acc];
      if (v && in_ready === 1'b1) begin
        acc_edge[n_acc] = cyc + 1;
        n_acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; start = 1'b0; tw_re = '0; tw_im = '0; in_re = '0; in_im = '0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 60; c++) begin
      if (done === 1'b1) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_s_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    checks++; if ({out_re, out_im, out_idx} !== '0) begin errors++; $display("FAIL reset_data got %h %h %h want 0", out_re, out_im, out_idx); end
    rst_s_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) set_vec(i, 256, 0, 256, 0);
    set_vec(3, 256, 0, 0, 256);
    do_start(0, 256);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_run got busy=%b ready=%b want 1 1", busy, in_ready); end
    do_stream(0, 16'h0, -1);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (oq_cyc.size() != 4) begin errors++; $display("FAIL basic_count got %0d want 4", oq_cyc.size()); end
    for (int i = 0; i < 4 && i < oq_cyc.size(); i++) begin
      checks++; if (oq_cyc[i] != acc_edge[i] + 7) begin errors++; $display("FAIL basic_lat%0d got %0d want %0d", i, oq_cyc[i], acc_edge[i] + 7); end
      checks++; if (oq_re[i] !== exp_re[i] || oq_im[i] !== exp_im[i]) begin errors++; $display("FAIL basic_data%0d got %h,%h want %h,%h", i, oq_re[i], oq_im[i], exp_re[i], exp_im[i]); end
    end
    checks++; if (dq.size() != 1 || oq_cyc.size() != 4 || dq[0] != oq_cyc[3] + 1) begin errors++; $display("FAIL basic_done got %0d pulses want 1 after last output", dq.size()); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b ready=%b want 0 0", busy, in_ready); end
  endtask

  task automatic test_sign();
    set_vec(0, 100, -7, 100, -7);
    set_vec(1, -1, 5, -1, 5);
    set_vec(2, 32767, -32768, 32767, -32768);
    set_vec(3, -256, 128, -128, -256);
    do_start(0, 256);
    do_stream(0, 16'h0, -1);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (oq_cyc.size() != 4) begin errors++; $display("FAIL sign_count got %0d want 4", oq_cyc.size()); end
    for (int i = 0; i < 4 && i < oq_cyc.size(); i++) begin
      checks++; if (oq_re[i] !== exp_re[i] || oq_im[i] !== exp_im[i]) begin errors++; $display("FAIL sign_data%0d got %h,%h want %h,%h", i, oq_re[i], oq_im[i], exp_re[i], exp_im[i]); end
    end
  endtask

  task automatic test_gaps();
    set_vec(0, 1, 2, 1, 2);
    set_vec(1, 3, 4, 3, 4);
    set_vec(2, 5, 6, 5, 6);
    set_vec(3, 7, 8, -8, 7);
    do_start(0, 256);
    do_stream(7, 16'b1011001, -1);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (oq_cyc.size() != 4) begin errors++; $display("FAIL gaps_count got %0d want 4", oq_cyc.size()); end
    for (int i = 0; i < 4 && i < oq_cyc.size(); i++) begin
      checks++; if (oq_cyc[i] != acc_edge[i] + 7) begin errors++; $display("FAIL gaps_lat%0d got %0d want %0d", i, oq_cyc[i], acc_edge[i] + 7); end
      checks++; if (oq_idx[i] !== 2'(i)) begin errors++; $display("FAIL gaps_idx%0d got %0d want %0d", i, oq_idx[i], i); end
      checks++; if (oq_re[i] !== exp_re[i] || oq_im[i] !== exp_im[i]) begin errors++; $display("FAIL gaps_data%0d got %h,%h want %h,%h", i, oq_re[i], oq_im[i], exp_re[i], exp_im[i]); end
    end
  endtask

  task automatic test_start_ignored();
    set_vec(0, 10, 20, 10, 20);
    set_vec(1, 30, 40, 30, 40);
    set_vec(2, 50, 60, 50, 60);
    // (3,-5)*(128,64)/256: re 704>>>8=2, im -448>>>8=-2
    set_vec(3, 3, -5, 2, -2);
    do_start(128, 64);
    do_stream(0, 16'h0, 2);
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL drain_ready got ready=%b busy=%b want 0 1", in_ready, busy); end
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", in_ready); end
    checks++; if (oq_cyc.size() != 4) begin errors++; $display("FAIL ign_count got %0d want 4", oq_cyc.size()); end
    for (int i = 0; i < 4 && i < oq_cyc.size(); i++) begin
      checks++; if (oq_re[i] !== exp_re[i] || oq_im[i] !== exp_im[i]) begin errors++; $display("FAIL ign_data%0d got %h,%h want %h,%h", i, oq_re[i], oq_im[i], exp_re[i], exp_im[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_start(0, 256);
    in_valid = 1'b1; in_re = 16'sd11; in_im = 16'sd12;
    @(posedge clk); #1;
    in_re = 16'sd13; in_im = 16'sd14;
    @(posedge clk); #1;
    in_valid = 1'b0; in_re = '0; in_im = '0;
    rst_s_n = 1'b0;
    @(posedge clk); #1;
    rst_s_n = 1'b1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_state got busy=%b ready=%b want 0 0", busy, in_ready); end
    repeat (15) @(posedge clk);
    #1;
    checks++; if (oq_cyc.size() != 0 || dq.size() != 0) begin errors++; $display("FAIL rstmid_flush got %0d outputs %0d done want 0 0", oq_cyc.size(), dq.size()); end
    set_vec(0, 256, 0, 256, 0);
    set_vec(1, 0, -256, 0, -256);
    set_vec(2, 64, 32, 64, 32);
    set_vec(3, 256, 0, 0, 256);
    do_start(0, 256);
    do_stream(0, 16'h0, -1);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (oq_cyc.size() != 4) begin errors++; $display("FAIL rstmid_count got %0d want 4", oq_cyc.size()); end
    for (int i = 0; i < 4 && i < oq_cyc.size(); i++) begin
      checks++; if (oq_re[i] !== exp_re[i] || oq_im[i] !== exp_im[i] || oq_idx[i] !== 2'(i)) begin errors++; $display("FAIL rstmid_data%0d got %h,%h idx %0d want %h,%h idx %0d", i, oq_re[i], oq_im[i], oq_idx[i], exp_re[i], exp_im[i], i); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) set_vec(i, 256, 0, 256, 0);
    set_vec(3, 256, 0, 0, 256);
    do_start(0, 256);
    do_stream(0, 16'h0, -1);
    wait_done();
    @(posedge clk); #1;
    checks++; if (oq_cyc.size() != 4 || dq.size() != 1) begin errors++; $display("FAIL b2b_first got %0d outputs %0d done want 4 1", oq_cyc.size(), dq.size()); end
    set_vec(0, 10, 20, 10, 20);
    set_vec(1, 30, 40, 30, 40);
    set_vec(2, 50, 60, 50, 60);
    set_vec(3, 3, -5, 2, -2);
    do_start(128, 64);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_start got busy=%b ready=%b want 1 1", busy, in_ready); end
    do_stream(0, 16'h0, -1);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (oq_cyc.size() != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", oq_cyc.size()); end
    for (int i = 0; i < 4 && i < oq_cyc.size(); i++) begin
      checks++; if (oq_idx[i] !== 2'(i)) begin errors++; $display("FAIL b2b_idx%0d got %0d want %0d", i, oq_idx[i], i); end
      checks++; if (oq_re[i] !== exp_re[i] || oq_im[i] !== exp_im[i]) begin errors++; $display("FAIL b2b_data%0d got %h,%h want %h,%h", i, oq_re[i], oq_im[i], exp_re[i], exp_im[i]); end
    end
    checks++; if (dq.size() != 1 || oq_cyc.size() != 4 || dq[0] != oq_cyc[3] + 1) begin errors++; $display("FAIL b2b_done got %0d pulses want 1 after last output", dq.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_gaps();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
